// File: rtl/stage_memory.sv
// Memory stage: latches execute results, runs lw/sw through a req/ready handshake, emits writeback bundle.
// Optional macro EXC_STATUS_EN: overflowing add/addi/sub write an exception code to r30 instead of rd.
module stage_memory #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              valid_in,
    input  logic [4:0]        opcode,
    input  logic [4:0]        alu_op,
    input  logic [4:0]        rd,
    input  logic [DATA_W-1:0] o_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] pc_plus_4,
    input  logic              overflow_in,
    output logic              stall_out,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_ADDI  = 5'b00101;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;

    typedef enum logic {IDLE, MEM} state_t;

    typedef struct packed {
        logic              we;
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
    } wb_t;

    state_t state, state_nxt;
    logic   accept_mem, accept_alu, mem_done;
    logic   is_mem_op;
    wb_t    wb_base, wb_sel;

    // Captured alongside the memory request so the completion cycle knows where to write
    logic       ld_p1;
    logic [4:0] rd_p1;

    function automatic wb_t wb_select(
        input logic [4:0]        op,
        input logic [4:0]        rd_i,
        input logic [DATA_W-1:0] o_i,
        input logic [DATA_W-1:0] pc_i
    );
        wb_t r;
        r.we   = 1'b0;
        r.rd   = rd_i;
        r.data = o_i;
        case (op)
            OP_RTYPE, OP_ADDI: r.we = 1'b1;
            OP_JAL: begin
                r.we   = 1'b1;
                r.rd   = 5'd31;
                r.data = pc_i;
            end
            OP_SETX: begin
                r.we = 1'b1;
                r.rd = 5'd30;
            end
            default: r.we = 1'b0;
        endcase
        return r;
    endfunction

    assign is_mem_op = (opcode == OP_LW) || (opcode == OP_SW);
    assign stall_out = (state == MEM);
    assign wb_base   = wb_select(opcode, rd, o_in, pc_plus_4);

`ifdef EXC_STATUS_EN
    always_comb begin
        wb_sel = wb_base;
        if (overflow_in) begin
            if (opcode == OP_RTYPE && alu_op == 5'b00000) begin
                wb_sel.rd   = 5'd30;
                wb_sel.data = DATA_W'(1);
            end else if (opcode == OP_ADDI) begin
                wb_sel.rd   = 5'd30;
                wb_sel.data = DATA_W'(2);
            end else if (opcode == OP_RTYPE && alu_op == 5'b00001) begin
                wb_sel.rd   = 5'd30;
                wb_sel.data = DATA_W'(3);
            end
        end
    end
`else
    logic unused_exc;
    assign unused_exc = ^{alu_op, overflow_in};
    assign wb_sel     = wb_base;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        accept_mem = 1'b0;
        accept_alu = 1'b0;
        mem_done   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (is_mem_op) begin
                        accept_mem = 1'b1;
                        state_nxt  = MEM;
                    end else begin
                        accept_alu = 1'b1;
                    end
                end
            end
            MEM: begin
                if (mem_ready) begin
                    mem_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- p1: request registers and writeback bundle ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ld_p1     <= 1'b0;
            rd_p1     <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            if (accept_alu) begin
                wb_valid <= 1'b1;
                wb_we    <= wb_sel.we && (wb_sel.rd != 5'd0);
                wb_rd    <= wb_sel.rd;
                wb_data  <= wb_sel.data;
            end
            if (accept_mem) begin
                mem_req   <= 1'b1;
                mem_we    <= (opcode == OP_SW);
                mem_addr  <= o_in[ADDR_W-1:0];
                mem_wdata <= b_in;
                ld_p1     <= (opcode == OP_LW);
                rd_p1     <= rd;
            end
            if (mem_done) begin
                mem_req  <= 1'b0;
                mem_we   <= 1'b0;
                wb_valid <= 1'b1;
                wb_we    <= ld_p1 && (rd_p1 != 5'd0);
                wb_rd    <= rd_p1;
                wb_data  <= ld_p1 ? mem_rdata : '0;
            end
        end
    end

endmodule
